muldiv_exec_unit: RTL and testbench
===================================

Name: muldiv_exec_unit

Overview:
Iterative RV32M multiply/divide unit in the Execute stage. Consumes the decoded operation and forwarded operands that arrive from the Decode-to-Execute pipeline register, and holds the pipeline via a stall request while it iterates. Produces one registered 32-bit result with a single-cycle done strobe. The Execute-stage result mux selects that result into the Execute-to-Memory register.

Parameters:
XLEN, 32, operand/result width; only 32 is supported.
ITER, 32, shift-add / restoring-divide iterations, one per cycle; equals XLEN.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  reset; asynchronous assert, active-low.
StartE  in  1  M-extension op valid in Execute this cycle.
FlushE  in  1  abort the current op (trap/redirect).
FuncE  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
SrcAE  in  32  rs1 operand, post-forwarding.
SrcBE  in  32  rs2 operand, post-forwarding.
BusyE  out  1  stall request for F/D/E; combinational.
DoneE  out  1  one-cycle strobe; ResultE valid.
ResultE  out  32  registered result.

Behaviour:
- Reset (RST_N=0, async): state IDLE, iteration count 0, internal accumulators 0, ResultE=0, DoneE=0. BusyE is forced to 0 while reset is asserted.
- States and transitions:
  - IDLE: BusyE = StartE & ~FlushE.
    - On StartE & ~FlushE, latch FuncE, the operand magnitudes, and the result sign.
    - Divide by zero, or DIV/REM with 0x80000000 / 0xFFFFFFFF: go directly to DONE.
    - Otherwise go to RUN with count=0.
  - RUN: BusyE=1; one iteration per cycle.
    - Multiply: 64-bit shift-add on magnitudes.
    - Divide: restoring, 1 quotient bit per cycle.
    - When count==ITER-1, go to DONE; otherwise count+1.
  - DONE: BusyE=0, DoneE=1, ResultE updated on entry. StartE is ignored in this cycle, because the same instruction is leaving E. Always go to IDLE next.
- Latency, normal op: BusyE is high for 33 cycles (IDLE accept + 32 RUN). DONE is the 34th cycle, and the pipeline advances at the end of it.
- Latency, special cases: BusyE high for 1 cycle; DONE on the 2nd cycle.
- Back-to-back M ops: the next op is accepted in the IDLE cycle right after DONE, with no extra bubble.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: rs1 signed, rs2 unsigned.
  - MULHU, DIVU, REMU: unsigned.
  - Signed ops use magnitudes internally, with a final two's-complement negate when the result sign is 1.
  - Remainder takes the dividend's sign.
- Result selection:
  - MUL returns product[31:0]; MULH, MULHSU and MULHU return product[63:32].
  - Divide by zero: DIV/DIVU return 0xFFFFFFFF; REM/REMU return the dividend unchanged.
  - Signed overflow (0x80000000 / -1): DIV returns 0x80000000; REM returns 0.
- ResultE holds its value until the next DONE. It is not cleared on IDLE or on flush.
- DoneE is high only in DONE, for exactly one cycle per completed op.
- FlushE:
  - In any state, go to IDLE on the next edge; no DONE; ResultE unchanged.
  - In DONE, flush suppresses nothing already visible: DoneE stays 1 this cycle, and the downstream kill is the pipeline's job.
  - Flush has priority over StartE in IDLE.
- Reset mid-operation: immediate return to the reset state; no DoneE afterwards.
- Operand changes on SrcAE/SrcBE after acceptance are ignored.

Test Plan:
- MUL 7 x 0xFFFFFFFD (-3):
  - BusyE high for 33 cycles; DoneE on cycle 34; ResultE=0xFFFFFFEB.
  - Next cycle: BusyE=0, DoneE=0.
- High-word multiplies:
  - MULH 0x80000000 x 0x80000000 -> 0x40000000.
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Divide/remainder:
  - DIV -7/2 -> 0xFFFFFFFD; REM -7,2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100,7 -> 2.
  - Each takes 34 cycles.
- Special cases, each with BusyE high 1 cycle and DoneE on cycle 2:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5,0 -> 5.
  - DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- Back-to-back: DIVU then MUL with StartE held.
  - Exactly two DoneE pulses, 34 cycles apart.
  - The second op is not restarted during the first op's DONE.
- Abort and reset:
  - FlushE during RUN count 10 -> IDLE next cycle, BusyE=0, no DoneE, ResultE keeps its prior value.
  - RST_N low mid-RUN -> BusyE=0 and ResultE=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/muldiv_exec_unit.sv
// Iterative RV32M multiply/divide unit for the Execute stage.
// One shift-add or restoring-divide step per cycle; stalls F/D/E while busy.
module muldiv_exec_unit #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            StartE,
    input  logic            FlushE,
    input  logic [2:0]      FuncE,
    input  logic [XLEN-1:0] SrcAE,
    input  logic [XLEN-1:0] SrcBE,
    output logic            BusyE,
    output logic            DoneE,
    output logic [XLEN-1:0] ResultE
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LastCnt = CW'(ITER - 1);
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    logic [CW-1:0]     count;
    logic [2:0]        funcQ;
    logic              negRes;
    logic [XLEN-1:0]   opMag;
    logic [2*XLEN-1:0] acc;
    logic [2*XLEN-1:0] accNext;

    logic            accept;
    logic            isRem;
    logic            aSigned;
    logic            bSigned;
    logic            aNeg;
    logic            bNeg;
    logic            divZero;
    logic            divOvf;
    logic            special;
    logic [XLEN-1:0] aMag;
    logic [XLEN-1:0] bMag;
    logic [XLEN-1:0] specRes;

    assign accept  = StartE & ~FlushE;
    assign isRem   = FuncE[2] & FuncE[1];
    assign aSigned = (FuncE == 3'd1) | (FuncE == 3'd2)
                   | (FuncE == 3'd4) | (FuncE == 3'd6);
    assign bSigned = (FuncE == 3'd1) | (FuncE == 3'd4)
                   | (FuncE == 3'd6);
    assign aNeg    = aSigned & SrcAE[XLEN-1];
    assign bNeg    = bSigned & SrcBE[XLEN-1];
    assign aMag    = aNeg ? -SrcAE : SrcAE;
    assign bMag    = bNeg ? -SrcBE : SrcBE;
    assign divZero = FuncE[2] & (SrcBE == '0);
    assign divOvf  = FuncE[2] & ~FuncE[0]
                   & (SrcAE == MinNeg) & (SrcBE == '1);
    assign special = divZero | divOvf;

    always_comb begin
        specRes = '0;
        unique case (1'b1)
            divZero: specRes = FuncE[1] ? SrcAE : '1;
            divOvf:  specRes = FuncE[1] ? '0 : MinNeg;
            default: specRes = '0;
        endcase
    end

    // Multiply: low half of acc holds the multiplier, shifted out LSB first.
    logic [XLEN:0]     mulSum;
    logic [2*XLEN-1:0] mulNext;

    assign mulSum  = {1'b0, acc[2*XLEN-1:XLEN]}
                   + {1'b0, (acc[0] ? opMag : '0)};
    assign mulNext = {mulSum, acc[XLEN-1:1]};

    // Divide: {rem, quot} shifts left, quotient bits enter at the bottom.
    logic [XLEN:0]     divShift;
    logic              divGe;
    logic [XLEN-1:0]   divRem;
    logic [2*XLEN-1:0] divNext;

    assign divShift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign divGe    = divShift >= {1'b0, opMag};
    assign divRem   = divGe ? (divShift[XLEN-1:0] - opMag)
                            : divShift[XLEN-1:0];
    assign divNext  = {divRem, acc[XLEN-2:0], divGe};

    assign accNext = funcQ[2] ? divNext : mulNext;

    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   divSel;
    logic [XLEN-1:0]   divFix;
    logic [XLEN-1:0]   mulSel;
    logic [XLEN-1:0]   runRes;

    assign prodFix = negRes ? -accNext : accNext;
    assign divSel  = funcQ[1] ? accNext[2*XLEN-1:XLEN]
                              : accNext[XLEN-1:0];
    assign divFix  = negRes ? -divSel : divSel;
    assign mulSel  = (funcQ[1:0] == 2'd0) ? prodFix[XLEN-1:0]
                                          : prodFix[2*XLEN-1:XLEN];
    assign runRes  = funcQ[2] ? divFix : mulSel;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        BusyE     = 1'b0;
        unique case (state)
            IDLE: begin
                BusyE = accept;
                if (accept) begin
                    stateNext = special ? DONE : RUN;
                end
            end
            RUN: begin
                BusyE = 1'b1;
                if (FlushE) begin
                    stateNext = IDLE;
                end else if (count == LastCnt) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
        if (!RST_N) begin
            BusyE = 1'b0;
        end
    end

    assign DoneE = (state == DONE);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            count   <= '0;
            funcQ   <= '0;
            negRes  <= 1'b0;
            opMag   <= '0;
            acc     <= '0;
            ResultE <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        funcQ  <= FuncE;
                        count  <= '0;
                        negRes <= isRem ? aNeg : (aNeg ^ bNeg);
                        if (FuncE[2]) begin
                            opMag <= bMag;
                            acc   <= {{XLEN{1'b0}}, aMag};
                        end else begin
                            opMag <= aMag;
                            acc   <= {{XLEN{1'b0}}, bMag};
                        end
                        if (special) begin
                            ResultE <= specRes;
                        end
                    end
                end
                RUN: begin
                    if (!FlushE) begin
                        acc   <= accNext;
                        count <= count + 1'b1;
                        if (count == LastCnt) begin
                            ResultE <= runRes;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Directed bench for muldiv_exec_unit: results, latency, flush, reset.
module tb_muldiv_exec_unit;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        StartE;
    logic        FlushE;
    logic [2:0]  FuncE;
    logic [31:0] SrcAE;
    logic [31:0] SrcBE;
    logic        BusyE;
    logic        DoneE;
    logic [31:0] ResultE;

    int checks = 0;
    int failures = 0;

    muldiv_exec_unit #(.XLEN(32), .ITER(32)) dut (
        .CLK(CLK),
        .RST_N(RST_N),
        .StartE(StartE),
        .FlushE(FlushE),
        .FuncE(FuncE),
        .SrcAE(SrcAE),
        .SrcBE(SrcBE),
        .BusyE(BusyE),
        .DoneE(DoneE),
        .ResultE(ResultE)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Issue one op, hold StartE for the accept cycle only, scramble operands.
    task automatic runOp(input string tag,
                         input logic [2:0] f,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int expBusy,
                         input logic [31:0] expRes);
        int busyCnt;
        int doneCyc;
        logic [31:0] res;
        busyCnt = 0;
        doneCyc = 0;
        res = '0;
        StartE = 1'b1;
        FuncE = f;
        SrcAE = a;
        SrcBE = b;
        for (int cyc = 1; cyc <= 60 && doneCyc == 0; cyc++) begin
            @(negedge CLK);
            if (BusyE) busyCnt++;
            if (DoneE) begin
                doneCyc = cyc;
                res = ResultE;
            end
            tick();
            StartE = 1'b0;
            SrcAE = $urandom;
            SrcBE = $urandom;
        end
        chk({tag, "_busy_cycles"}, busyCnt, expBusy);
        chk({tag, "_done_cycle"}, doneCyc, expBusy + 1);
        chk({tag, "_result"}, res, expRes);
        @(negedge CLK);
        chk({tag, "_post_busy"}, 32'(BusyE), 0);
        chk({tag, "_post_done"}, 32'(DoneE), 0);
        chk({tag, "_post_result"}, ResultE, expRes);
        tick();
    endtask

    initial begin
        int nDone;
        int d1;
        int d2;
        logic [31:0] r1;
        logic [31:0] r2;

        RST_N = 1'b0;
        StartE = 1'b1;
        FlushE = 1'b0;
        FuncE = 3'd0;
        SrcAE = 32'd5;
        SrcBE = 32'd3;
        @(negedge CLK);
        chk("rst_busy_forced", 32'(BusyE), 0);
        chk("rst_done", 32'(DoneE), 0);
        chk("rst_result", ResultE, 0);
        StartE = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();

        runOp("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 33, 32'hFFFFFFEB);
        runOp("mulh_min", 3'd1, 32'h80000000, 32'h80000000,
              33, 32'h40000000);
        runOp("mulhu_max", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF,
              33, 32'hFFFFFFFE);
        runOp("mulhsu_m1", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
              33, 32'hFFFFFFFF);
        runOp("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFD);
        runOp("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 33, 32'hFFFFFFFF);
        runOp("div_7_m2", 3'd4, 32'd7, 32'hFFFFFFFE, 33, 32'hFFFFFFFD);
        runOp("rem_7_m2", 3'd6, 32'd7, 32'hFFFFFFFE, 33, 32'd1);
        runOp("divu_100_7", 3'd5, 32'd100, 32'd7, 33, 32'd14);
        runOp("remu_100_7", 3'd7, 32'd100, 32'd7, 33, 32'd2);
        runOp("divu_min_max", 3'd5, 32'h80000000, 32'hFFFFFFFF, 33, 32'd0);
        runOp("div_by_zero", 3'd4, 32'd5, 32'd0, 1, 32'hFFFFFFFF);
        runOp("remu_by_zero", 3'd7, 32'd5, 32'd0, 1, 32'd5);
        runOp("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 1, 32'h80000000);
        runOp("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 1, 32'd0);

        // Back-to-back with StartE held: DIVU then MUL.
        nDone = 0;
        d1 = 0;
        d2 = 0;
        r1 = '0;
        r2 = '0;
        StartE = 1'b1;
        FuncE = 3'd5;
        SrcAE = 32'd100;
        SrcBE = 32'd7;
        for (int cyc = 1; cyc <= 90; cyc++) begin
            @(negedge CLK);
            if (cyc == 34) chk("b2b_busy_in_done", 32'(BusyE), 0);
            if (cyc == 35) chk("b2b_busy_accept2", 32'(BusyE), 1);
            if (DoneE) begin
                nDone++;
                if (d1 == 0) begin
                    d1 = cyc;
                    r1 = ResultE;
                end else begin
                    d2 = cyc;
                    r2 = ResultE;
                end
            end
            tick();
            if (d1 != 0 && d2 == 0 && cyc == d1) begin
                FuncE = 3'd0;
                SrcAE = 32'd7;
                SrcBE = 32'hFFFFFFFD;
            end
            if (d2 != 0) StartE = 1'b0;
        end
        chk("b2b_done_count", nDone, 2);
        chk("b2b_first_done", d1, 34);
        chk("b2b_spacing", d2 - d1, 34);
        chk("b2b_result1", r1, 32'd14);
        chk("b2b_result2", r2, 32'hFFFFFFEB);

        // Flush at RUN count 10 (cycle 12 after accept).
        StartE = 1'b1;
        FuncE = 3'd5;
        SrcAE = 32'd100;
        SrcBE = 32'd7;
        tick();
        StartE = 1'b0;
        repeat (10) tick();
        FlushE = 1'b1;
        @(negedge CLK);
        chk("flush_busy_in_run", 32'(BusyE), 1);
        tick();
        FlushE = 1'b0;
        @(negedge CLK);
        chk("flush_busy_after", 32'(BusyE), 0);
        chk("flush_done_after", 32'(DoneE), 0);
        tick();

        // Flush beats StartE in IDLE.
        StartE = 1'b1;
        FlushE = 1'b1;
        FuncE = 3'd0;
        SrcAE = 32'd3;
        SrcBE = 32'd3;
        @(negedge CLK);
        chk("flush_prio_busy", 32'(BusyE), 0);
        tick();
        StartE = 1'b0;
        FlushE = 1'b0;
        nDone = 0;
        repeat (45) begin
            @(negedge CLK);
            if (DoneE) nDone++;
        end
        chk("flush_no_done", nDone, 0);
        chk("flush_result_kept", ResultE, 32'hFFFFFFEB);
        tick();

        // Asynchronous reset in the middle of RUN.
        StartE = 1'b1;
        FuncE = 3'd0;
        SrcAE = 32'd7;
        SrcBE = 32'hFFFFFFFD;
        tick();
        StartE = 1'b0;
        repeat (4) tick();
        chk("rst_mid_busy_before", 32'(BusyE), 1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("rst_mid_busy", 32'(BusyE), 0);
        chk("rst_mid_result", ResultE, 0);
        chk("rst_mid_done", 32'(DoneE), 0);
        tick();
        RST_N = 1'b1;
        nDone = 0;
        repeat (45) begin
            @(negedge CLK);
            if (DoneE) nDone++;
        end
        chk("rst_mid_no_done", nDone, 0);
        tick();

        runOp("recover_divu", 3'd5, 32'd100, 32'd7, 33, 32'd14);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
